regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised register file for the full processor: N read ports, one write port, write-through bypass.
//  Adds a per-register busy scoreboard so multi-cycle units (mult/div) mark a destination pending at issue.
//  Decode reads data and busy status for the operands; the stall logic consumes the busy flags.
//  Replaces the fixed 32x32 two-port file; a same-cycle write is forwarded instead of driving high-Z.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   register address width; DEPTH = 2**ADDR_W
//  NUM_RD    2   number of read ports (1..4)
//  ZERO_REG  1   1: register 0 reads 0, ignores writes and busy-set
//  BYPASS    1   1: a same-cycle write is forwarded to matching read ports
// PORTS
//  clock             in   1              rising-edge clock
//  ctrl_reset        in   1              asynchronous, active-high reset
//  ctrl_writeEnable  in   1              write data_writeReg on the next edge
//  ctrl_writeReg     in   ADDR_W         write address
//  data_writeReg     in   DATA_W         write data
//  ctrl_busySet      in   1              mark ctrl_busyReg pending on the next edge
//  ctrl_busyReg      in   ADDR_W         destination of the issuing multi-cycle op
//  ctrl_readReg      in   NUM_RD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
//  data_readReg      out  NUM_RD*DATA_W  read data; port i at [i*DATA_W +: DATA_W]
//  read_busy         out  NUM_RD         1: operand of port i still pending
//  busy_count        out  ADDR_W+1       number of registers currently busy
//  dbg_addr          in   ADDR_W         debug/LED readout address
//  dbg_data          out  DATA_W         registers[dbg_addr], no bypass
// BEHAVIOUR
//  Reset is asynchronous and active-high; it applies immediately, including mid-write.
//   - All registers go to 0; busy vector goes to 0.
//   - While reset is held: data_readReg=0, read_busy=0, busy_count=0, dbg_data=0.
//   - Writes and busy-set are ignored during reset.
//  Write: at posedge, if ctrl_writeEnable and the target is writable, registers[ctrl_writeReg] <= data_writeReg.
//   - The target is not writable when ZERO_REG=1 and ctrl_writeReg==0.
//   - A write also clears busy[ctrl_writeReg]; this is how the pending result retires.
//  Busy set: at posedge, if ctrl_busySet, busy[ctrl_busyReg] <= 1.
//   - Ignored for reg 0 when ZERO_REG=1.
//  Simultaneous write and busy-set:
//   - Different addresses: both take effect.
//   - Same address: write data is stored AND busy ends at 1 (the new issue wins).
//  Busy-set on an already-busy register: no change; busy_count does not increment.
//  Read ports are combinational, zero latency. For port i with address a:
//   - ZERO_REG=1 and a==0: data=0, read_busy=0.
//   - BYPASS=1, ctrl_writeEnable, ctrl_writeReg==a: data=data_writeReg, read_busy=0 (the result is in flight now).
//   - Otherwise: data=registers[a], read_busy=busy[a].
//   - With BYPASS=0: always registers[a] / busy[a], so a write is visible from the next cycle.
//   - A same-cycle ctrl_busySet does not affect read_busy until after the edge.
//  busy_count = popcount(busy); it reflects registered state, so it updates the cycle after set/clear.
//   - Maximum value: DEPTH-ZERO_REG.
//  All read ports are independent; any number may hit the same address.
//  Out-of-range addresses cannot occur, because DEPTH = 2**ADDR_W.
// STRUCTURE
//  processor_defs.vh holds the shared constants, included by the decode and stall logic:
//   - default DATA_W and ADDR_W;
//   - REG_ZERO index;
//   - mult/div destination register index.
//  Sub-module busy_scoreboard (DEPTH, ADDR_W):
//   - contains the busy vector, set/clear priority and popcount;
//   - outputs the busy vector and busy_count.
//  regfile_sb contains:
//   - the storage array;
//   - a generate loop over NUM_RD for the read/bypass muxes;
//   - the debug port.
// TESTING
//  T1 reset: write 0xDEADBEEF to r5, assert ctrl_reset mid-cycle
//      -> r5 reads 0 immediately; busy_count=0.
//  T2 bypass: write r7=0x1234 while port0 and port1 both read r7
//      -> both return 0x1234 that cycle (BYPASS=1); with BYPASS=0 they return the old value, then 0x1234.
//  T3 zero reg: write r0=0xFFFFFFFF and busySet r0
//      -> r0 reads 0, read_busy=0, busy_count=0.
//  T4 scoreboard: busySet r9 -> next cycle read_busy=1, busy_count=1.
//      Then write r9=0x55 -> same cycle data=0x55 and read_busy=0; after the edge busy_count=0.
//  T5 collision: write r3=0xA and busySet r3 in one cycle
//      -> afterwards r3 reads 0xA, read_busy=1, busy_count=1.
//  T6 fill: busySet r1..r31 on consecutive cycles
//      -> busy_count reaches 31; a repeat busySet r4 leaves it at 31; dbg_addr=4 shows stored data.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared constants and read-source selection for the register file with busy scoreboard.
// Decode and stall logic import this package for register indices and default widths.
package regfile_sb_pkg;

    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_ADDR_W      = 5;
    localparam int unsigned REG_ZERO        = 0;
    localparam int unsigned REG_MULDIV_DEST = 31;

    typedef enum logic [1:0] {
        RdSrcZero   = 2'd0,
        RdSrcBypass = 2'd1,
        RdSrcArray  = 2'd2
    } rd_src_e;

    // Zero (reset or hard-wired r0) outranks the bypass, which outranks the array.
    function automatic rd_src_e rd_src_sel(input logic is_zero, input logic bypass_hit);
        if (is_zero) begin
            return RdSrcZero;
        end else if (bypass_hit) begin
            return RdSrcBypass;
        end
        return RdSrcArray;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Write/busy-set/read/debug bundle between decode (master) and the register file (slave).
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = 2
);

    logic                       ctrl_writeEnable;
    logic [ADDR_W-1:0]          ctrl_writeReg;
    logic [DATA_W-1:0]          data_writeReg;
    logic                       ctrl_busySet;
    logic [ADDR_W-1:0]          ctrl_busyReg;
    logic [NUM_RD*ADDR_W-1:0]   ctrl_readReg;
    logic [NUM_RD*DATA_W-1:0]   data_readReg;
    logic [NUM_RD-1:0]          read_busy;
    logic [ADDR_W:0]            busy_count;
    logic [ADDR_W-1:0]          dbg_addr;
    logic [DATA_W-1:0]          dbg_data;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output ctrl_busySet, ctrl_busyReg, ctrl_readReg, dbg_addr,
        input  data_readReg, read_busy, busy_count, dbg_data
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  ctrl_busySet, ctrl_busyReg, ctrl_readReg, dbg_addr,
        output data_readReg, read_busy, busy_count, dbg_data
    );

endinterface

// File: rtl/regfile_sb_busy_scoreboard.sv
// Per-register pending flags for multi-cycle results: set at issue, cleared by the retiring write.
module regfile_sb_busy_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              i_clr,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic              i_set,
    input  logic [ADDR_W-1:0] i_set_addr,
    output logic [DEPTH-1:0]  o_busy,
    output logic [ADDR_W:0]   o_busy_count
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_d;
    logic             w_set_ok;
    logic [ADDR_W:0]  w_count;

    assign w_set_ok = i_set && !((ZERO_REG != 0) && (i_set_addr == ADDR_W'(REG_ZERO)));

    // Set is applied after clear so a same-address issue keeps the register pending.
    always_comb begin
        w_busy_d = r_busy;
        if (i_clr) begin
            w_busy_d[i_clr_addr] = 1'b0;
        end
        if (w_set_ok) begin
            w_busy_d[i_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    always_comb begin
        w_count = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_count = w_count + (ADDR_W + 1)'(r_busy[i]);
        end
    end

    assign o_busy       = r_busy;
    assign o_busy_count = w_count;

endmodule

// File: rtl/regfile_sb.sv
// Register file with N combinational read ports, one write port, write-through bypass
// and a busy scoreboard reporting pending operands to the stall logic.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic         clock,
    input  logic         ctrl_reset,
    regfile_sb_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  w_busy;
    logic              w_wr_ok;

    assign w_wr_ok = bus.ctrl_writeEnable &&
                     !((ZERO_REG != 0) && (bus.ctrl_writeReg == ADDR_W'(REG_ZERO)));

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[bus.ctrl_writeReg] <= bus.data_writeReg;
        end
    end

    regfile_sb_busy_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .i_clr        (w_wr_ok),
        .i_clr_addr   (bus.ctrl_writeReg),
        .i_set        (bus.ctrl_busySet),
        .i_set_addr   (bus.ctrl_busyReg),
        .o_busy       (w_busy),
        .o_busy_count (bus.busy_count)
    );

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_is_zero;
        logic              w_hit;
        rd_src_e           w_src;
        logic [DATA_W-1:0] w_data;
        logic              w_rbusy;

        assign w_addr    = bus.ctrl_readReg[g*ADDR_W +: ADDR_W];
        // Reset forces zero so a write held across reset is not bypassed out.
        assign w_is_zero = ctrl_reset || ((ZERO_REG != 0) && (w_addr == ADDR_W'(REG_ZERO)));
        assign w_hit     = (BYPASS != 0) && bus.ctrl_writeEnable && (bus.ctrl_writeReg == w_addr);
        assign w_src     = rd_src_sel(w_is_zero, w_hit);

        always_comb begin
            w_data  = '0;
            w_rbusy = 1'b0;
            unique case (w_src)
                RdSrcZero: begin
                    w_data  = '0;
                    w_rbusy = 1'b0;
                end
                RdSrcBypass: begin
                    w_data  = bus.data_writeReg;
                    w_rbusy = 1'b0;
                end
                RdSrcArray: begin
                    w_data  = r_regs[w_addr];
                    w_rbusy = w_busy[w_addr];
                end
                default: begin
                    w_data  = '0;
                    w_rbusy = 1'b0;
                end
            endcase
        end

        assign bus.data_readReg[g*DATA_W +: DATA_W] = w_data;
        assign bus.read_busy[g]                     = w_rbusy;
    end

    assign bus.dbg_data = r_regs[bus.dbg_addr];

endmodule
